// File: rtl/usb_tx_arbiter_if.sv
// rtl/usb_tx_arbiter_if.sv - requester and FIFO write-port bundle for usb_tx_arbiter
interface usb_tx_arbiter_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0]   req;
    logic [NCH*8-1:0] req_len;
    logic [NCH*8-1:0] ch_data;
    logic [NCH-1:0]   ch_dvalid;
    logic [NCH-1:0]   ch_dready;
    logic [NCH-1:0]   grant;
    logic             busy;
    logic             full;
    logic             valid;
    logic [7:0]       dout;

    modport master (
        input  req, req_len, ch_data, ch_dvalid, full,
        output ch_dready, grant, busy, valid, dout
    );

    modport slave (
        output req, req_len, ch_data, ch_dvalid, full,
        input  ch_dready, grant, busy, valid, dout
    );
endinterface

// File: rtl/usb_tx_arbiter.sv
// rtl/usb_tx_arbiter.sv - round-robin framer sharing one USB TX FIFO write port
module usb_tx_arbiter #(
    parameter int         NCH     = 4,
    parameter int         CW      = 2,
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic              clk,
    input  logic              rst_n,
    usb_tx_arbiter_if.master  bus
);

    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   ch_idx;
    logic [CW-1:0]   pick_idx;
    logic            pick_found;
    logic [CW:0]     cand;
    logic [7:0]      len_q;
    logic [7:0]      cnt;
    logic            ob_valid;
    logic [7:0]      ob_data;
    logic            reg_free;
    logic            load;
    logic [7:0]      load_byte;
    logic [7:0]      ch_byte;
    logic            ch_dv;

    // The output register can take a byte when empty or when its byte leaves this edge.
    assign reg_free = !ob_valid || !bus.full;
    assign ch_byte  = bus.ch_data[{ch_idx, 3'b000} +: 8];
    assign ch_dv    = bus.ch_dvalid[ch_idx];

    assign bus.valid = ob_valid;
    assign bus.dout  = ob_data;

    // Scan downward so the last hit is the first requester at or above ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (CW+1)'(k);
            if (cand >= (CW+1)'(NCH)) begin
                cand = cand - (CW+1)'(NCH);
            end
            if (bus.req[cand[CW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_found) state_nxt = HDR;
            HDR:  if (load) state_nxt = LEN;
            LEN:  if (load) state_nxt = (len_q == 8'd0) ? DONE : DATA;
            DATA: if (load && cnt == 8'd1) state_nxt = DONE;
            DONE: if (!ob_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ch_dready = '0;
        bus.grant     = '0;
        bus.busy      = (state != IDLE);
        load          = 1'b0;
        load_byte     = 8'h00;
        if (state != IDLE) begin
            bus.grant[ch_idx] = 1'b1;
        end
        case (state)
            HDR: begin
                load      = reg_free;
                load_byte = {HDR_TAG, 4'(ch_idx)};
            end
            LEN: begin
                load      = reg_free;
                load_byte = len_q;
            end
            DATA: begin
                bus.ch_dready[ch_idx] = reg_free;
                load      = reg_free && ch_dv;
                load_byte = ch_byte;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            ch_idx   <= '0;
            len_q    <= 8'h00;
            cnt      <= 8'h00;
            ob_valid <= 1'b0;
            ob_data  <= 8'h00;
        end else begin
            if (state == IDLE && pick_found) begin
                ch_idx <= pick_idx;
                len_q  <= bus.req_len[{pick_idx, 3'b000} +: 8];
                ptr    <= (pick_idx == CW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (state == LEN && load) begin
                cnt <= len_q;
            end else if (state == DATA && load) begin
                cnt <= cnt - 8'd1;
            end
            if (load) begin
                ob_valid <= 1'b1;
                ob_data  <= load_byte;
            end else if (!bus.full) begin
                ob_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb/tb_usb_tx_arbiter.sv - directed self-checking bench for usb_tx_arbiter
module tb_usb_tx_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    usb_tx_arbiter_if #(.NCH(4)) bus ();

    usb_tx_arbiter #(.NCH(4), .CW(2), .HDR_TAG(4'hA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Per-channel payload producers
    logic [7:0] pay [4][1024];
    int         plen [4] = '{0, 0, 0, 0};
    logic [9:0] pidx [4] = '{10'd0, 10'd0, 10'd0, 10'd0};
    logic [3:0] stall = 4'b0000;
    logic [3:0] dv;
    logic [31:0] dd;

    always_comb begin
        dv = '0;
        dd = '0;
        for (int i = 0; i < 4; i++) begin
            dv[i]        = (int'(pidx[i]) < plen[i]) && !stall[i];
            dd[i*8 +: 8] = pay[i][pidx[i]];
        end
    end
    assign bus.ch_dvalid = dv;
    assign bus.ch_data   = dd;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.ch_dvalid[i] && bus.ch_dready[i]) pidx[i] <= pidx[i] + 10'd1;
        end
    end

    // FIFO-side monitor
    int         cyc = 0;
    logic [7:0] out_log [4096];
    int         out_cyc [4096];
    int         out_n = 0;
    int         hold_err = 0;
    int         dready_err = 0;
    int         seen3 = 0;
    logic       prev_vf = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid && !bus.full && out_n < 4096) begin
            out_log[out_n] = bus.dout;
            out_cyc[out_n] = cyc;
            out_n++;
        end
        if (prev_vf && (!bus.valid || bus.dout !== prev_dout)) hold_err++;
        if ((bus.ch_dready & ~bus.grant) != 4'b0000 || $countones(bus.ch_dready) > 1) dready_err++;
        if (bus.ch_dready[3]) seen3++;
        prev_vf   = bus.valid && bus.full;
        prev_dout = bus.dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_ch(input int ch, input int n, input logic [7:0] b0,
                           input logic [7:0] step, input logic [7:0] len);
        int base;
        base = int'(pidx[ch]);
        for (int k = 0; k < n; k++) pay[ch][base + k] = b0 + 8'(k) * step;
        plen[ch] = base + n;
        bus.req_len[ch*8 +: 8] = len;
    endtask

    task automatic wait_out(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_n >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_grant(input logic [3:0] mask, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.grant === mask) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_pidx(input int ch, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(pidx[ch]) >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid); else n_pass++;
        n_total++; if (bus.dout !== 8'h00) $display("FAIL reset_dout got %h want 00", bus.dout); else n_pass++;
        n_total++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", bus.grant); else n_pass++;
        n_total++; if (bus.ch_dready !== 4'b0000) $display("FAIL reset_dready got %b want 0000", bus.ch_dready); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) $display("FAIL idle_after_reset busy=%b valid=%b want 0 0", bus.busy, bus.valid); else n_pass++;
    endtask

    task automatic test_single();
        logic [7:0] exp [5];
        int start;
        bit ok;
        exp = '{8'hA1, 8'h03, 8'h11, 8'h22, 8'h33};
        tick();
        load_ch(1, 3, 8'h11, 8'h11, 8'd3);
        start = out_n;
        bus.req = 4'b0010;
        wait_grant(4'b0010, 20, ok);
        n_total++; if (!ok) $display("FAIL single_grant got %b want 0010", bus.grant); else n_pass++;
        bus.req = 4'b0000;
        wait_out(start + 5, 50, ok);
        n_total++; if (!ok) $display("FAIL single_timeout got %0d bytes want 5", out_n - start); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (out_log[start + k] !== exp[k]) $display("FAIL single_byte%0d got %h want %h", k, out_log[start + k], exp[k]);
            else n_pass++;
        end
        for (int k = 1; k < 5; k++) begin
            n_total++;
            if (out_cyc[start + k] !== out_cyc[start] + k) $display("FAIL single_cycle%0d got %0d want %0d", k, out_cyc[start + k], out_cyc[start] + k);
            else n_pass++;
        end
        wait_idle(50, ok);
        repeat (3) @(negedge clk);
        n_total++; if (bus.grant !== 4'b0000) $display("FAIL single_grant_end got %b want 0000", bus.grant); else n_pass++;
        n_total++; if (out_n - start !== 5) $display("FAIL single_count got %0d want 5", out_n - start); else n_pass++;
    endtask

    task automatic test_round_robin();
        int start;
        bit ok;
        logic [7:0] hexp, pexp;
        do_reset();
        for (int i = 0; i < 4; i++) load_ch(i, 3, 8'h40 + 8'(16 * i), 8'h01, 8'd1);
        start = out_n;
        bus.req = 4'b1111;
        wait_out(start + 15, 200, ok);
        bus.req = 4'b0000;
        n_total++; if (!ok) $display("FAIL rr_timeout got %0d bytes want 15", out_n - start); else n_pass++;
        for (int b = 0; b < 5; b++) begin
            hexp = {4'hA, 4'(b % 4)};
            pexp = 8'h40 + 8'(16 * (b % 4)) + 8'(b / 4);
            n_total++;
            if (out_log[start + 3*b] !== hexp) $display("FAIL rr_hdr%0d got %h want %h", b, out_log[start + 3*b], hexp);
            else n_pass++;
            n_total++;
            if (out_log[start + 3*b + 1] !== 8'h01) $display("FAIL rr_len%0d got %h want 01", b, out_log[start + 3*b + 1]);
            else n_pass++;
            n_total++;
            if (out_log[start + 3*b + 2] !== pexp) $display("FAIL rr_pay%0d got %h want %h", b, out_log[start + 3*b + 2], pexp);
            else n_pass++;
        end
        wait_idle(50, ok);
        repeat (4) @(negedge clk);
        n_total++; if (out_n - start !== 15) $display("FAIL rr_count got %0d want 15", out_n - start); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [6];
        int start, hold0, i;
        bit ok;
        exp = '{8'hA2, 8'h04, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        tick();
        load_ch(2, 4, 8'hB0, 8'h01, 8'd4);
        start = out_n;
        hold0 = hold_err;
        bus.req = 4'b0100;
        wait_grant(4'b0100, 20, ok);
        bus.req = 4'b0000;
        for (i = 0; i < 100; i++) begin
            tick();
            bus.full = ~bus.full;
            if (!bus.busy) break;
        end
        bus.full = 1'b0;
        n_total++; if (i >= 100) $display("FAIL bp_timeout got busy=%b want 0", bus.busy); else n_pass++;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_total++;
            if (out_log[start + k] !== exp[k]) $display("FAIL bp_byte%0d got %h want %h", k, out_log[start + k], exp[k]);
            else n_pass++;
        end
        n_total++; if (out_n - start !== 6) $display("FAIL bp_count got %0d want 6", out_n - start); else n_pass++;
        n_total++; if (hold_err !== hold0) $display("FAIL bp_hold got %0d unstable cycles want 0", hold_err - hold0); else n_pass++;
    endtask

    task automatic test_zero_len();
        int start, seen0;
        bit ok;
        tick();
        load_ch(3, 0, 8'h00, 8'h00, 8'd0);
        start = out_n;
        seen0 = seen3;
        bus.req = 4'b1000;
        wait_grant(4'b1000, 20, ok);
        bus.req = 4'b0000;
        wait_idle(50, ok);
        n_total++; if (!ok) $display("FAIL zl_idle got busy=%b want 0", bus.busy); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (out_log[start] !== 8'hA3) $display("FAIL zl_hdr got %h want a3", out_log[start]); else n_pass++;
        n_total++; if (out_log[start + 1] !== 8'h00) $display("FAIL zl_len got %h want 00", out_log[start + 1]); else n_pass++;
        n_total++; if (out_n - start !== 2) $display("FAIL zl_count got %0d want 2", out_n - start); else n_pass++;
        n_total++; if (seen3 !== seen0) $display("FAIL zl_dready got %0d cycles want 0", seen3 - seen0); else n_pass++;
    endtask

    task automatic test_stall();
        logic [7:0] exp [6];
        int start, base;
        bit ok;
        exp = '{8'hA0, 8'h04, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
        tick();
        load_ch(0, 4, 8'hC0, 8'h01, 8'd4);
        base = int'(pidx[0]);
        start = out_n;
        bus.req = 4'b0001;
        wait_grant(4'b0001, 20, ok);
        bus.req = 4'b0000;
        wait_pidx(0, base + 2, 50, ok);
        stall[0] = 1'b1;
        repeat (5) @(negedge clk);
        n_total++; if (bus.valid !== 1'b0) $display("FAIL stall_drain got valid=%b want 0", bus.valid); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL stall_busy got %b want 1", bus.busy); else n_pass++;
        stall[0] = 1'b0;
        wait_idle(50, ok);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_total++;
            if (out_log[start + k] !== exp[k]) $display("FAIL stall_byte%0d got %h want %h", k, out_log[start + k], exp[k]);
            else n_pass++;
        end
        n_total++; if (out_n - start !== 6) $display("FAIL stall_count got %0d want 6", out_n - start); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int start, base;
        bit ok;
        tick();
        load_ch(2, 8, 8'hD0, 8'h01, 8'd8);
        load_ch(1, 1, 8'hE0, 8'h01, 8'd1);
        load_ch(3, 1, 8'hF0, 8'h01, 8'd1);
        base = int'(pidx[2]);
        bus.req = 4'b0100;
        wait_grant(4'b0100, 20, ok);
        bus.req = 4'b0000;
        wait_pidx(2, base + 2, 50, ok);
        n_total++; if (!ok) $display("FAIL rm_data got %0d bytes want 2", int'(pidx[2]) - base); else n_pass++;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_total++; if (bus.valid !== 1'b0) $display("FAIL rm_valid got %b want 0", bus.valid); else n_pass++;
        n_total++; if (bus.grant !== 4'b0000) $display("FAIL rm_grant got %b want 0000", bus.grant); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rm_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.ch_dready !== 4'b0000) $display("FAIL rm_dready got %b want 0000", bus.ch_dready); else n_pass++;
        bus.req = 4'b1010;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start = out_n;
        wait_grant(4'b0010, 20, ok);
        n_total++; if (!ok) $display("FAIL rm_regrant got %b want 0010", bus.grant); else n_pass++;
        bus.req = 4'b0000;
        wait_out(start + 3, 50, ok);
        n_total++; if (out_log[start] !== 8'hA1) $display("FAIL rm_hdr got %h want a1", out_log[start]); else n_pass++;
        n_total++; if (out_log[start + 2] !== 8'hE0) $display("FAIL rm_pay got %h want e0", out_log[start + 2]); else n_pass++;
        wait_idle(50, ok);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d want completion", cyc);
        $fatal(1);
    end

    initial begin
        bus.req     = 4'b0000;
        bus.req_len = '0;
        bus.full    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_zero_len();
        test_stall();
        test_reset_mid();
        n_total++; if (dready_err !== 0) $display("FAIL dready_onehot got %0d bad cycles want 0", dready_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
- Shares the single USB TX FIFO write port (byte `dout`/`valid`, back-pressured by `full`) between NCH independent byte-stream requesters.
- Grants one requester at a time, round-robin, and emits a framed burst: header byte, length byte, then exactly `len` payload bytes pulled from the granted channel.
- Sits between per-channel producers (test pattern generators, sensor packers) and the USB FIFO write driver.

Parameters:
- NCH, 4, number of requesters (2..16).
- CW, 2, channel index width, = clog2(NCH); CW ≤ 4.
- HDR_TAG, 4'hA, upper nibble of header byte.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  async active-low reset.
- req  input  NCH  per-channel burst request; held high until granted.
- req_len  input  NCH*8  per-channel payload length (bytes 0..255); channel i at [8i+7:8i]; stable while req[i]=1.
- ch_data  input  NCH*8  per-channel payload byte; same packing as req_len.
- ch_dvalid  input  NCH  per-channel payload byte valid.
- ch_dready  output  NCH  per-channel payload byte accepted (one-hot or zero).
- grant  output  NCH  one-hot current owner; zero when idle.
- busy  output  1  burst in progress.
- full  input  1  USB FIFO full.
- valid  output  1  byte on dout offered to FIFO.
- dout  output  8  byte to FIFO.

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous, active-low.
  - Outputs on reset: valid=0, dout=8'h00, grant=0, ch_dready=0, busy=0.
  - State IDLE; round-robin pointer=0, so channel 0 has highest priority first.
- FIFO handshake: a byte transfers on any rising edge with valid=1 and full=0.
  - valid/dout come from a one-entry output register.
  - The register loads a new byte when it is empty or being transferred in the same cycle.
  - While full=1, valid and dout hold stable.
- Arbitration (IDLE):
  - If any req is set, choose the first set bit searching from pointer upward, with wrap-around.
  - grant and busy assert the next cycle; go to HDR; latch channel index and req_len.
  - Pointer := granted+1 mod NCH, so the just-served channel has lowest priority next.
- HDR: load output register with {HDR_TAG, 0-padded ch index}, then go to LEN.
- LEN: load the latched length byte.
  - len=0: go to DONE.
  - Otherwise go to DATA with remaining counter=len.
- DATA:
  - ch_dready[g] = output register free this cycle (empty or transferring).
  - When ch_dvalid[g] & ch_dready[g]: load ch_data[g] and decrement the counter.
  - When the counter reaches 0 after a load, go to DONE.
  - ch_dvalid low stalls with no timeout; ch_dready is never asserted for non-granted channels.
- DONE:
  - Wait until the last byte has left the output register (register empty).
  - Then deassert grant/busy and return to IDLE.
  - Minimum one idle cycle between bursts.
- Throughput: with full=0 and data always valid, one byte per cycle from HDR through the last payload byte; burst occupies len+2 FIFO bytes.
- Requester dropping req mid-burst: ignored; the burst completes using the latched length.
- req_len changes after grant: ignored (latched value used).
- full asserted at any point: output holds, and ch_dready drops in the same cycle if the register is occupied; no byte is lost or duplicated.
- Reset mid-burst: immediate abort to reset values; the partial frame is not completed.

Test Plan:
- Single channel: req[1]=1, len=3, data 11,22,33, full=0 → dout sequence A1,03,11,22,33 on 5 consecutive cycles; grant=0010 during the burst, then 0.
- Round-robin: all four req high, len=1 each → headers appear in order A0,A1,A2,A3, then A0 again if still requesting; no channel is served twice while another waits.
- Back-pressure: len=4, toggle full every other cycle during payload → exactly A2,04,b0..b3 reach the FIFO, each exactly once; dout stable whenever valid&full.
- Zero length: req[3], len=0 → dout A3,00, then return to IDLE; ch_dready[3] never asserts.
- Payload stall: ch_dvalid low for 5 cycles mid-burst → valid deasserts after the register drains; resumes with the correct next byte; total byte count = len+2.
- Async reset mid-DATA: rst_n low between clocks → valid, grant, busy and ch_dready drop immediately; after release, first burst serves the lowest-index requester (pointer=0).
